// File: rtl/gate_response_checker_pkg.sv
// Shared definitions for the 2-input gate response checker:
// gate function codes, FSM states, expected-pipe entry and the reference gate.
package gate_response_checker_pkg;

    localparam logic [1:0] FN_NAND = 2'd0;
    localparam logic [1:0] FN_NOR  = 2'd1;
    localparam logic [1:0] FN_AND  = 2'd2;
    localparam logic [1:0] FN_OR   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One in-flight sample: expected c plus the {a,b} that produced it.
    typedef struct packed {
        logic       valid;
        logic       exp;
        logic [1:0] ab;
    } pipe_ent_t;

    function automatic logic gate_f(
        input logic [1:0] fn,
        input logic       a,
        input logic       b
    );
        case (fn)
            FN_NAND: return ~(a & b);
            FN_NOR:  return ~(a | b);
            FN_AND:  return a & b;
            default: return a | b;
        endcase
    endfunction

endpackage

// File: rtl/gate_response_checker_exp_pipe.sv
// LAT-deep shift register of expected-value entries with synchronous flush.
// Ports: clk, rst (async high), flush, in_ent -> out_ent (stage LAT-1), empty.
module gate_response_checker_exp_pipe
    import gate_response_checker_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    input  pipe_ent_t in_ent,
    output pipe_ent_t out_ent,
    output logic      empty
);

    pipe_ent_t stage [LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LAT; k++) stage[k] <= '0;
        end else if (flush) begin
            for (int k = 0; k < LAT; k++) stage[k] <= '0;
        end else begin
            stage[0] <= in_ent;
            for (int k = 1; k < LAT; k++) stage[k] <= stage[k-1];
        end
    end

    assign out_ent = stage[LAT-1];

    always_comb begin
        empty = 1'b1;
        for (int k = 0; k < LAT; k++) begin
            if (stage[k].valid) empty = 1'b0;
        end
    end

endmodule

// File: rtl/gate_response_checker.sv
// Clocked response checker for a 2-input gate DUT: compares c against f(a,b)
// LAT cycles after sample_valid, tracks truth-table coverage, reports pass/fail.
// Ports: clk, rst (async high), start, sample_valid, a, b, c in;
//        busy, done, pass, timeout, err_cnt, cov, first_err_ab out.
module gate_response_checker
    import gate_response_checker_pkg::*;
#(
    parameter logic [1:0] FUNC    = FN_NAND,
    parameter int         LAT     = 1,
    parameter int         MIN_SMP = 8,
    parameter int         TMO     = 256,
    parameter int         ERR_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sample_valid,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [ERR_W-1:0] err_cnt,
    output logic [3:0]       cov,
    output logic [1:0]       first_err_ab
);

    localparam int CW = $clog2(MIN_SMP + 1);
    localparam int TW = $clog2(TMO + 1);

    state_t        state;
    logic [CW-1:0] smp_cnt;
    logic [TW-1:0] tmo_cnt;
    pipe_ent_t     in_ent;
    pipe_ent_t     out_ent;
    logic          pipe_empty;
    logic          run;
    logic          cmp;
    logic          mism;
    logic          complete;
    logic          tmo_hit;
    logic          flush;

    assign run = (state == ST_RUN);

    // A start cycle discards both the incoming sample and the due compare.
    assign in_ent.valid = run && !start && sample_valid;
    assign in_ent.exp   = gate_f(FUNC, a, b);
    assign in_ent.ab    = {a, b};

    assign cmp  = run && !start && out_ent.valid;
    assign mism = cmp && (c != out_ent.exp);

    assign complete = (cov == 4'hF)
                   && (smp_cnt >= CW'(MIN_SMP))
                   && pipe_empty;
    assign tmo_hit  = (tmo_cnt == TW'(TMO - 1));

    // Entries still in flight when the run times out are dropped.
    assign flush = start || (run && !complete && tmo_hit);

    gate_response_checker_exp_pipe #(
        .LAT (LAT)
    ) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .in_ent  (in_ent),
        .out_ent (out_ent),
        .empty   (pipe_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            timeout      <= 1'b0;
            err_cnt      <= '0;
            cov          <= '0;
            first_err_ab <= '0;
            smp_cnt      <= '0;
            tmo_cnt      <= '0;
        end else if (start) begin
            state        <= ST_RUN;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            timeout      <= 1'b0;
            err_cnt      <= '0;
            cov          <= '0;
            first_err_ab <= '0;
            smp_cnt      <= '0;
            tmo_cnt      <= '0;
        end else if (run) begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (cmp) begin
                if (smp_cnt != CW'(MIN_SMP)) smp_cnt <= smp_cnt + 1'b1;
                cov[out_ent.ab] <= 1'b1;
            end
            if (mism) begin
                if (err_cnt == '0) first_err_ab <= out_ent.ab;
                if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            end
            // No compare can coincide with completion: the pipe is empty.
            if (complete) begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= (err_cnt == '0);
            end else if (tmo_hit) begin
                state   <= ST_DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
                pass    <= 1'b0;
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gate_response_checker.sv
// Randomized self-checking bench for gate_response_checker: two instances
// (NAND/LAT=1 and NOR/LAT=3) checked against a per-session reference model.
module tb_gate_response_checker;

    localparam int TMO  = 512;
    localparam int MINS = 8;
    localparam int M    = 600;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic sample_valid;
    logic a;
    logic b;
    logic c1;
    logic c3;

    logic [1:0] busy_w;
    logic [1:0] done_w;
    logic [1:0] pass_w;
    logic [1:0] tmo_w;
    logic [7:0] err_w [2];
    logic [3:0] cov_w [2];
    logic [1:0] fe_w  [2];

    bit sv_a [M];
    bit a_a  [M];
    bit b_a  [M];
    bit c_a  [2][M];

    int fn_of  [2] = '{0, 1};
    int lat_of [2] = '{1, 3};

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    gate_response_checker #(
        .FUNC(2'd0), .LAT(1), .MIN_SMP(MINS), .TMO(TMO), .ERR_W(8)
    ) u1 (
        .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
        .a(a), .b(b), .c(c1),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .timeout(tmo_w[0]), .err_cnt(err_w[0]), .cov(cov_w[0]),
        .first_err_ab(fe_w[0])
    );

    gate_response_checker #(
        .FUNC(2'd1), .LAT(3), .MIN_SMP(MINS), .TMO(TMO), .ERR_W(8)
    ) u3 (
        .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
        .a(a), .b(b), .c(c3),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .timeout(tmo_w[1]), .err_cnt(err_w[1]), .cov(cov_w[1]),
        .first_err_ab(fe_w[1])
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit ref_f(input int fn, input bit x, input bit y);
        case (fn)
            0:       return !(x && y);
            1:       return !(x || y);
            2:       return x && y;
            default: return x || y;
        endcase
    endfunction

    // pat 0: 00,01,10,11 cycling; 1: random; 2: only 00/01.
    task automatic gen(input int n, input int pat, input int gap);
        int k;
        bit [1:0] ab;
        k = 0;
        for (int t = 0; t < M; t++) begin
            ab = 2'($urandom_range(3));
            if (pat == 2) ab[1] = 1'b0;
            if (pat == 0) ab = 2'(k % 4);
            sv_a[t] = (t < n) && ($urandom_range(99) >= gap);
            if (sv_a[t]) k++;
            a_a[t] = ab[1];
            b_a[t] = ab[0];
        end
    endtask

    // mode 0: correct after lag; 1: stuck-at-1; 2: inverted.
    task automatic make_c(input int i, input int mode, input int lag,
                          input int flip);
        bit v;
        for (int t = 0; t < M; t++) begin
            if (t < lag || mode == 1) v = 1'b1;
            else if (sv_a[t-lag])
                v = ref_f(fn_of[i], a_a[t-lag], b_a[t-lag])
                    ^ (mode == 2) ^ ($urandom_range(99) < flip);
            else v = 1'($urandom_range(1));
            c_a[i][t] = v;
        end
    endtask

    // Session outcome from the rules: sample issued in run cycle s is judged
    // against c of cycle s+L; the run ends once all four {a,b} have been seen,
    // MINS samples judged and nothing is still in flight, or at cycle TMO-1.
    task automatic model(input int i, output int end_t, output int tmo,
                         output int err, output int cov, output int first);
        int  cnt;
        int  l;
        int  ab;
        bit  pend;
        cnt = 0;
        l = lat_of[i];
        end_t = -1; tmo = 0; err = 0; cov = 0; first = 0;
        for (int t = 0; t < M; t++) begin
            pend = 0;
            for (int s = t - l; s < t; s++)
                if (s >= 0 && sv_a[s]) pend = 1;
            if (cov == 15 && cnt >= MINS && !pend) begin
                end_t = t;
                return;
            end
            if (t - l >= 0 && sv_a[t-l]) begin
                ab = a_a[t-l] * 2 + b_a[t-l];
                cnt++;
                cov = cov | (1 << ab);
                if (c_a[i][t] != ref_f(fn_of[i], a_a[t-l], b_a[t-l])) begin
                    if (err == 0) first = ab;
                    if (err < 255) err++;
                end
            end
            if (t == TMO - 1) begin
                tmo = 1;
                end_t = t;
                return;
            end
        end
    endtask

    // Start cycle carries a sample of {1,1} with c=1 which must be ignored.
    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1; sample_valid = 1'b1;
        a = 1'b1; b = 1'b1; c1 = 1'b1; c3 = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic session(input string nm);
        int e_end [2];
        int e_tmo [2];
        int e_err [2];
        int e_cov [2];
        int e_fe  [2];
        int seen  [2];
        for (int i = 0; i < 2; i++)
            model(i, e_end[i], e_tmo[i], e_err[i], e_cov[i], e_fe[i]);
        seen[0] = -1;
        seen[1] = -1;
        start_pulse();
        for (int t = 0; t < M; t++) begin
            sample_valid = sv_a[t];
            a  = a_a[t];
            b  = b_a[t];
            c1 = c_a[0][t];
            c3 = c_a[1][t];
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++)
                if (seen[i] < 0 && done_w[i]) seen[i] = t;
            if (seen[0] >= 0 && seen[1] >= 0) break;
            @(negedge clk);
        end
        sample_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_u%0d_end", nm, i), seen[i], e_end[i]);
            check($sformatf("%s_u%0d_done", nm, i), int'(done_w[i]), 1);
            check($sformatf("%s_u%0d_busy", nm, i), int'(busy_w[i]), 0);
            check($sformatf("%s_u%0d_tmo", nm, i), int'(tmo_w[i]), e_tmo[i]);
            check($sformatf("%s_u%0d_err", nm, i), int'(err_w[i]), e_err[i]);
            check($sformatf("%s_u%0d_cov", nm, i), int'(cov_w[i]), e_cov[i]);
            check($sformatf("%s_u%0d_fe", nm, i), int'(fe_w[i]), e_fe[i]);
            check($sformatf("%s_u%0d_pass", nm, i), int'(pass_w[i]),
                  int'(e_err[i] == 0 && e_tmo[i] == 0));
        end
    endtask

    task automatic check_idle(input string nm);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_u%0d_busy", nm, i), int'(busy_w[i]), 0);
            check($sformatf("%s_u%0d_done", nm, i), int'(done_w[i]), 0);
            check($sformatf("%s_u%0d_pass", nm, i), int'(pass_w[i]), 0);
            check($sformatf("%s_u%0d_tmo", nm, i), int'(tmo_w[i]), 0);
            check($sformatf("%s_u%0d_err", nm, i), int'(err_w[i]), 0);
            check($sformatf("%s_u%0d_cov", nm, i), int'(cov_w[i]), 0);
            check($sformatf("%s_u%0d_fe", nm, i), int'(fe_w[i]), 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sample_valid = 1'b0;
        a = 1'b0; b = 1'b0; c1 = 1'b0; c3 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("por");
        @(negedge clk);
        rst = 1'b0;

        // Correct DUTs, all four combinations twice.
        gen(8, 0, 0);
        make_c(0, 0, 1, 0);
        make_c(1, 0, 3, 0);
        session("nand_ok");
        check("nand_ok_pass_k", int'(pass_w[0]), 1);
        check("nand_ok_cov_k", int'(cov_w[0]), 15);

        // c stuck-at-1 on the NAND: only ab=11 mismatches.
        make_c(0, 1, 1, 0);
        session("stuck1");
        check("stuck1_err_k", int'(err_w[0]), 2);
        check("stuck1_fe_k", int'(fe_w[0]), 3);
        check("stuck1_pass_k", int'(pass_w[0]), 0);

        // Only ab=00/01 offered: coverage never completes.
        gen(M, 2, 30);
        make_c(0, 0, 1, 0);
        make_c(1, 0, 3, 0);
        session("tmo");
        check("tmo_flag_k", int'(tmo_w[0]), 1);
        check("tmo_cov_k", int'(cov_w[1]), 3);
        check("tmo_pass_k", int'(pass_w[1]), 0);

        // Back-to-back samples on LAT=3, then c one cycle early.
        gen(40, 1, 0);
        make_c(0, 0, 1, 0);
        make_c(1, 0, 3, 0);
        session("lat3");
        check("lat3_err_k", int'(err_w[1]), 0);
        make_c(1, 0, 2, 0);
        session("lat2");
        check("lat2_err_nz", int'(err_w[1] != 0), 1);

        // Restart while samples with wrong c are still in flight.
        @(negedge clk);
        start_pulse();
        sample_valid = 1'b1; a = 1'b1; b = 1'b1; c1 = 1'b1; c3 = 1'b1;
        repeat (5) @(negedge clk);
        gen(30, 1, 20);
        make_c(0, 0, 1, 0);
        make_c(1, 0, 3, 0);
        session("restart");

        // Error counter saturation.
        gen(300, 1, 0);
        make_c(0, 2, 1, 0);
        make_c(1, 0, 3, 0);
        session("sat");
        check("sat_err_k", int'(err_w[0]), 255);

        for (int r = 0; r < 6; r++) begin
            gen($urandom_range(8, 60), 1, $urandom_range(0, 50));
            make_c(0, $urandom_range(0, 2), 1, $urandom_range(0, 5));
            make_c(1, 0, 3, $urandom_range(0, 5));
            session($sformatf("rnd%0d", r));
        end

        // Asynchronous reset in the middle of a run with errors logged.
        start_pulse();
        sample_valid = 1'b1; a = 1'b1; b = 1'b1; c1 = 1'b1; c3 = 1'b1;
        repeat (6) @(negedge clk);
        check("rst_pre_busy", int'(busy_w[1]), 1);
        #2;
        rst = 1'b1;
        #1;
        check_idle("rst_async");
        @(posedge clk);
        #1;
        check_idle("rst_edge");
        @(negedge clk);
        rst = 1'b0;
        sample_valid = 1'b0;

        // A clean run straight out of reset.
        gen(12, 0, 0);
        make_c(0, 0, 1, 0);
        make_c(1, 0, 3, 0);
        session("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
